// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   rx_state_e     - receiver FSM state encoding
//   DATA_BITS_DEF  - default number of data bits per frame
//   PAR_ODD/EVEN   - values of the parity-select input
//   parity_bit()   - parity bit expected for a given data reduction-XOR
package uart_pkg;

   localparam int DATA_BITS_DEF = 8;

   localparam logic PAR_ODD  = 1'b0;
   localparam logic PAR_EVEN = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rx_state_e;

   // Odd parity makes the total count of ones odd, so the bit is the
   // inverted XOR of the data; even parity uses the XOR directly.
   function automatic logic parity_bit(input logic data_xor, input logic p_sel);
      return (p_sel == PAR_EVEN) ? data_xor : ~data_xor;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side handshake between the UART receiver and its consumer.
//   rx_data    - last received byte
//   rx_valid   - held byte not yet acknowledged
//   parity_err - parity mismatch on held byte
//   frame_err  - stop bit sampled low on held byte
//   overrun    - a byte was overwritten before acknowledge
//   busy       - receiver is inside a frame (not idle)
//   rx_ack     - consumer acknowledge of the held byte
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;
   logic                 busy;
   logic                 rx_ack;

   modport master (
      output rx_data, rx_valid, parity_err, frame_err, overrun, busy,
      input  rx_ack
   );

   modport slave (
      input  rx_data, rx_valid, parity_err, frame_err, overrun, busy,
      output rx_ack
   );
endinterface

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for the asynchronous serial line.
//   clk   - system clock
//   reset - asynchronous active-high reset (flops reset to 1 = idle line)
//   d     - asynchronous input
//   q     - synchronized output
module uart_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, data MSB first, parity, stop).
//   clk         - system clock
//   reset       - asynchronous active-high reset
//   sample_tick - one-clk strobe at OVERSAMPLE x baud
//   rx          - asynchronous serial line, idles high
//   p_sel       - parity select (0 = odd, 1 = even)
//   bus         - uart_rx_if.master: rx_data/rx_valid/flags/busy out, rx_ack in
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample_tick,
   input  logic       rx,
   input  logic       p_sel,
   uart_rx_if.master  bus
);
   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   // The 8th tick after start detection lands mid start bit.
   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   logic rx_s;

   uart_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   rx_state_e            state_q, state_d;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_bad_q, par_bad_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 done;

   always_comb begin
      state_d      = state_q;
      tick_cnt_d   = tick_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      par_bad_d    = par_bad_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      overrun_d    = overrun_q;
      done         = 1'b0;

      if (sample_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_d    = ST_START;
                  tick_cnt_d = '0;
               end
            end
            ST_START: begin
               if (tick_cnt_q == TICK_HALF) begin
                  // A line back high by mid start bit is treated as a glitch.
                  state_d    = rx_s ? ST_IDLE : ST_DATA;
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
            ST_DATA: begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  shreg_d    = {shreg_q[DATA_BITS-2:0], rx_s};
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d   = ST_PARITY;
                     bit_cnt_d = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
            ST_PARITY: begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  par_bad_d  = (rx_s != parity_bit(^shreg_q, p_sel));
                  state_d    = ST_STOP;
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
            ST_STOP: begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  done       = 1'b1;
                  state_d    = rx_s ? ST_IDLE : ST_BREAK;
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
            ST_BREAK: begin
               // Hold here while the line is low so a break is not a new start.
               if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // A completing frame wins over an acknowledge; an acknowledge in the
      // same clock only prevents the overrun flag.
      if (done) begin
         rx_data_d    = shreg_q;
         parity_err_d = par_bad_q;
         frame_err_d  = ~rx_s;
         rx_valid_d   = 1'b1;
         overrun_d    = rx_valid_q & ~bus.rx_ack;
      end else if (bus.rx_ack && rx_valid_q) begin
         rx_valid_d = 1'b0;
         overrun_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         tick_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         par_bad_q    <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         par_bad_q    <= par_bad_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.rx_data    = rx_data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.parity_err = parity_err_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.overrun    = overrun_q;
   assign bus.busy       = (state_q != ST_IDLE);
endmodule
